byte_word_loader: RTL and testbench
===================================

BYTE_WORD_LOADER -- requirements
Module: byte_word_loader

Interface
REQ-001 Parameter WORDS, default 32: number of 32-bit words per load image, range 1..128.
REQ-002 Parameter ADDR_W, default 7: width of mem_addr; WORDS SHALL be at most 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 load_start  input  1  one-cycle request to begin a new image load.
REQ-006 byte_in  input  8  incoming byte from the pads.
REQ-007 byte_valid  input  1  byte_in qualifier; a byte is accepted only when byte_valid and byte_ready are both 1.
REQ-008 byte_ready  output  1  high exactly while in LOAD.
REQ-009 mem_we  output  1  one-cycle write strobe to the word memory.
REQ-010 mem_addr  output  ADDR_W  word address of the current write.
REQ-011 mem_data  output  32  assembled word.
REQ-012 busy  output  1  high in LOAD or FLUSH.
REQ-013 done  output  1  high in DONE.
REQ-014 cpu_rst_n  output  1  active-low reset for the CPU core, registered.

Function
REQ-015 FSM states: IDLE, LOAD, FLUSH, DONE.
REQ-016 IDLE -> LOAD on load_start; byte_idx, word_idx and the lane register clear on that edge.
REQ-017 In LOAD, each accepted byte is written to lane byte_idx of the assembly register, little-endian (first byte to [7:0], fourth to [31:24]), and byte_idx increments modulo 4.
REQ-018 When the fourth byte of a word is accepted, the next cycle SHALL have mem_we=1, mem_data=assembled word and mem_addr=word_idx; word_idx increments after that write.
REQ-019 Write latency is 1 cycle after acceptance of the fourth byte; mem_we is never high for two consecutive cycles with the same mem_addr.
REQ-020 Byte acceptance continues in the cycle mem_we is high; back-to-back bytes at one per cycle SHALL lose no data.
REQ-021 When the fourth byte of word WORDS-1 is accepted, go to FLUSH; byte_ready drops in the same cycle as mem_we for that word.
REQ-022 FLUSH -> DONE after one cycle.
REQ-023 DONE -> LOAD on load_start (reload); otherwise remain in DONE.
REQ-024 load_start while in LOAD or FLUSH SHALL be ignored.
REQ-025 byte_valid outside LOAD SHALL be ignored, with no state change.
REQ-026 mem_we is 0 whenever it is not asserted per REQ-018; mem_data and mem_addr hold their last value.
REQ-027 cpu_rst_n = 1 only in the cycle after the state is DONE; it drops to 0 the cycle after DONE -> LOAD.
REQ-028 word_idx counts 0..WORDS-1 and SHALL never wrap within one load.

Reset
REQ-029 With rst_n=0 at a clock edge: state=IDLE, byte_idx=0, word_idx=0, assembly register=0, mem_we=0, mem_addr=0, mem_data=0, byte_ready=0, busy=0, done=0, cpu_rst_n=0.
REQ-030 Reset mid-load SHALL abandon the partial word without a write; memory contents already written are not cleared.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding (2 bits) and the constant BYTES_PER_WORD=4.
REQ-032 A single sub-module byte_packer (byte lane register plus byte_idx counter plus word-complete pulse) is natural; the FSM and word counter live in the top module.

Verification
REQ-033 Reset, then load_start with WORDS=2 and bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 streamed one per cycle -> writes 0x44332211@0 and 0x88776655@1, each exactly 1 cycle after its fourth byte; done=1 two cycles after the final byte; cpu_rst_n=1 one cycle later.
REQ-034 Same stream with byte_valid gapped (1 idle cycle between bytes) -> identical writes and addresses; mem_we pulses are one cycle wide.
REQ-035 byte_valid=1 with 0xAA in IDLE, then load_start -> 0xAA does not appear in any written word.
REQ-036 Assert rst_n=0 after 3 bytes of word 1 -> no write for word 1; all outputs take reset values next cycle; a fresh load then starts at mem_addr=0.
REQ-037 In DONE, pulse load_start -> cpu_rst_n=0 the next cycle, byte_ready=1, and the following writes restart at mem_addr=0.
REQ-038 load_start pulsed mid-LOAD -> no effect on byte_idx or word_idx; write sequence unchanged.

Source files
------------

// File: rtl/byte_word_loader_pkg.sv
// Shared constants for the byte-to-word image loader: FSM encoding and word geometry.
package byte_word_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/byte_word_loader_byte_packer.sv
// Little-endian byte lane assembler: collects four accepted bytes and flags the
// cycle in which the fourth arrives, presenting the completed word combinationally.
module byte_packer
    import byte_word_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_complete
);

    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [31:0]           lanes_q, lanes_d;

    always_comb begin
        word_next = lanes_q;
        word_next[{byte_idx_q, 3'b000} +: 8] = byte_in;
        word_complete = accept && (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

        lanes_d    = lanes_q;
        byte_idx_d = byte_idx_q;
        if (clear) begin
            lanes_d    = '0;
            byte_idx_d = '0;
        end else if (accept) begin
            lanes_d    = word_next;
            byte_idx_d = byte_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lanes_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            lanes_q    <= lanes_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/byte_word_loader.sv
// Boot image loader: packs a byte stream into 32-bit words, writes them to word
// memory in order, then releases the CPU core from reset.
//
//   state | meaning
//   IDLE  | waiting for the first load_start after reset
//   LOAD  | accepting bytes, writing each completed word
//   FLUSH | last word write in flight
//   DONE  | image complete, CPU released; load_start reloads
module byte_word_loader
    import byte_word_loader_pkg::*;
#(
    parameter int WORDS  = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              busy,
    output logic              done,
    output logic              cpu_rst_n
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;

    logic        accept;
    logic        start;
    logic [31:0] word_next;
    logic        word_complete;

    assign accept = byte_valid && (state_q == ST_LOAD);
    assign start  = load_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    byte_packer u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (start),
        .accept        (accept),
        .byte_in       (byte_in),
        .word_next     (word_next),
        .word_complete (word_complete)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (word_complete) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = word_idx_q;
                    mem_data_d = word_next;
                    // Hold at the last index so the counter never wraps within a load.
                    if (word_idx_q == LAST_IDX) state_d = ST_FLUSH;
                    else                        word_idx_d = word_idx_q + 1'b1;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE: begin
                if (start) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) word_idx_d = '0;

        // Released only while staying in DONE, so a reload re-asserts it immediately.
        cpu_rst_n_d = (state_q == ST_DONE) && (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_idx_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign byte_ready = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign done       = (state_q == ST_DONE);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign cpu_rst_n  = cpu_rst_n_q;

endmodule

// File: tb/tb_byte_word_loader.sv
// Directed bench for byte_word_loader with a two-word image.
module tb_byte_word_loader;

    localparam int WORDS  = 2;
    localparam int ADDR_W = 7;

    logic              clk;
    logic              rst_n;
    logic              load_start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              busy;
    logic              done;
    logic              cpu_rst_n;

    int n_checks = 0;
    int n_errors = 0;

    byte_word_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .cpu_rst_n  (cpu_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_cpu"},   32'(cpu_rst_n),  32'd0);
        chk({tag, "_we"},    32'(mem_we),     32'd0);
        chk({tag, "_addr"},  32'(mem_addr),   32'd0);
        chk({tag, "_data"},  mem_data,        32'd0);
    endtask

    task automatic start_load(input string tag);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk({tag, "_ready"}, 32'(byte_ready), 32'd1);
        chk({tag, "_busy"},  32'(busy),       32'd1);
        chk({tag, "_cpu"},   32'(cpu_rst_n),  32'd0);
    endtask

    // Streams n bytes of img (byte 0 first); gap idle cycles between bytes;
    // load_start is also raised with byte start_at (-1 for never).
    task automatic stream(input string tag, input logic [63:0] img, input int n,
                          input int gap, input int start_at);
        for (int i = 0; i < n; i++) begin
            byte_in    = img[8*i +: 8];
            byte_valid = 1'b1;
            load_start = (i == start_at);
            tick();
            byte_valid = 1'b0;
            load_start = 1'b0;
            if (i % 4 == 3) begin
                chk($sformatf("%s_we%0d", tag, i),   32'(mem_we),   32'd1);
                chk($sformatf("%s_addr%0d", tag, i), 32'(mem_addr), 32'(i / 4));
                chk($sformatf("%s_data%0d", tag, i), mem_data,      img[32*(i/4) +: 32]);
            end else begin
                chk($sformatf("%s_nowe%0d", tag, i), 32'(mem_we), 32'd0);
            end
            chk($sformatf("%s_ready%0d", tag, i), 32'(byte_ready), (i == 2*4-1) ? 32'd0 : 32'd1);
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk($sformatf("%s_width%0d", tag, i), 32'(mem_we), 32'd0);
                end
            end
        end
    endtask

    task automatic finish_load(input string tag);
        tick();
        chk({tag, "_done"},  32'(done),      32'd1);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_we"},    32'(mem_we),    32'd0);
        chk({tag, "_cpu0"},  32'(cpu_rst_n), 32'd0);
        tick();
        chk({tag, "_cpu1"},  32'(cpu_rst_n), 32'd1);
        chk({tag, "_done1"}, 32'(done),      32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Back-to-back stream
        start_load("t1_start");
        stream("t1", 64'h8877665544332211, 8, 0, -1);
        finish_load("t1_end");

        // Reload from DONE with one idle cycle between bytes
        start_load("t2_start");
        stream("t2", 64'h8877665544332211, 8, 1, -1);
        finish_load("t2_end");

        // load_start during LOAD must not disturb the sequence
        start_load("t3_start");
        stream("t3", 64'hDEADBEEFCAFEF00D, 8, 0, 2);
        finish_load("t3_end");

        // Bytes offered in IDLE are dropped
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        byte_in    = 8'hAA;
        byte_valid = 1'b1;
        tick();
        tick();
        chk("t4_idle_busy",  32'(busy),       32'd0);
        chk("t4_idle_ready", 32'(byte_ready), 32'd0);
        chk("t4_idle_we",    32'(mem_we),     32'd0);
        byte_valid = 1'b0;
        start_load("t4_start");
        stream("t4", 64'h0807060504030201, 8, 0, -1);
        finish_load("t4_end");

        // Reset after three bytes of word 1 abandons it
        start_load("t5_start");
        stream("t5", 64'h1122334455667788, 7, 0, -1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("t5_rst");
        rst_n = 1'b1;
        tick();
        chk("t5_nowrite", 32'(mem_we), 32'd0);
        chk("t5_idle",    32'(busy),   32'd0);
        start_load("t5_restart");
        stream("t5b", 64'h0F0E0D0C0B0A0908, 8, 0, -1);
        finish_load("t5_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
